// File: rtl/ifetch_bus_ctrl.sv
// Instruction-fetch sequencer: one single-beat Wishbone read per PC, with
// stall hold, flush abort and hung-slave timeout.
module ifetch_bus_ctrl #(
  parameter int unsigned TIMEOUT  = 256,
  parameter logic [31:0] NOP_INSN = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  stall_i,
  input  logic        flush_i,
  input  logic        cpu_ce_i,
  input  logic [31:0] cpu_addr_i,
  output logic [31:0] cpu_data_o,
  output logic        stallreq_o,
  output logic        err_o,
  output logic [31:0] wb_adr_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [3:0]  wb_sel_o
);

  localparam int unsigned TMO_W = $clog2(TIMEOUT);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE       = 2'd0,
    S_BUSY       = 2'd1,
    S_WAIT_STALL = 2'd2
  } state_t;

  state_t           state;
  logic [31:0]      rd_buf;
  logic [TMO_W-1:0] tmo_cnt;
  logic             tmo_hit;

  // Only the IF/ID hold bit of the stall vector matters to fetch.
  logic unused_stall;
  assign unused_stall = ^{stall_i[5:2], stall_i[0]};

  assign tmo_hit  = (tmo_cnt == TMO_LAST);
  assign wb_stb_o = wb_cyc_o;
  assign wb_we_o  = 1'b0;
  assign wb_sel_o = wb_cyc_o ? 4'hF : 4'h0;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= S_IDLE;
      wb_adr_o <= '0;
      wb_cyc_o <= 1'b0;
      rd_buf   <= '0;
      tmo_cnt  <= '0;
      err_o    <= 1'b0;
    end else begin
      err_o <= 1'b0;
      case (state)
        S_IDLE: begin
          if (cpu_ce_i && !flush_i) begin
            wb_cyc_o <= 1'b1;
            wb_adr_o <= cpu_addr_i;
            tmo_cnt  <= '0;
            state    <= S_BUSY;
          end
        end
        S_BUSY: begin
          // Flush beats ack, ack beats timeout.
          if (flush_i) begin
            wb_cyc_o <= 1'b0;
            rd_buf   <= '0;
            state    <= S_IDLE;
          end else if (wb_ack_i) begin
            wb_cyc_o <= 1'b0;
            rd_buf   <= wb_dat_i;
            state    <= stall_i[1] ? S_WAIT_STALL : S_IDLE;
          end else if (tmo_hit) begin
            wb_cyc_o <= 1'b0;
            err_o    <= 1'b1;
            state    <= S_IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
          end
        end
        S_WAIT_STALL: begin
          if (flush_i) begin
            rd_buf <= '0;
            state  <= S_IDLE;
          end else if (!stall_i[1]) begin
            state <= S_IDLE;
          end
        end
        default: begin
          wb_cyc_o <= 1'b0;
          state    <= S_IDLE;
        end
      endcase
    end
  end

  // Instruction and stall request are combinational so ack data reaches IF/ID with no extra cycle.
  always_comb begin
    cpu_data_o = NOP_INSN;
    stallreq_o = 1'b0;
    case (state)
      S_IDLE: stallreq_o = cpu_ce_i && !flush_i;
      S_BUSY: begin
        if (!flush_i) begin
          if (wb_ack_i) begin
            cpu_data_o = wb_dat_i;
          end else if (!tmo_hit) begin
            stallreq_o = 1'b1;
          end
        end
      end
      S_WAIT_STALL: cpu_data_o = rd_buf;
      default: begin
        cpu_data_o = NOP_INSN;
        stallreq_o = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_ifetch_bus_ctrl.sv
// Bench for ifetch_bus_ctrl: directed vector table, reset corner sequences,
// then random traffic against a transaction-level fetch model.
module tb_ifetch_bus_ctrl;

  localparam int unsigned TMO = 4;
  localparam logic [31:0] NOP = 32'h0000_0000;

  logic        clk;
  logic        rst;
  logic [5:0]  stall;
  logic        flush;
  logic        ce;
  logic [31:0] addr;
  logic [31:0] cpu_data;
  logic        stallreq;
  logic        err;
  logic [31:0] wb_adr;
  logic [31:0] wb_dat;
  logic        wb_ack;
  logic        wb_cyc;
  logic        wb_stb;
  logic        wb_we;
  logic [3:0]  wb_sel;

  int checks = 0;
  int failures = 0;

  ifetch_bus_ctrl #(.TIMEOUT(TMO), .NOP_INSN(NOP)) dut (
    .clk(clk), .rst(rst), .stall_i(stall), .flush_i(flush),
    .cpu_ce_i(ce), .cpu_addr_i(addr), .cpu_data_o(cpu_data),
    .stallreq_o(stallreq), .err_o(err), .wb_adr_o(wb_adr),
    .wb_dat_i(wb_dat), .wb_ack_i(wb_ack), .wb_cyc_o(wb_cyc),
    .wb_stb_o(wb_stb), .wb_we_o(wb_we), .wb_sel_o(wb_sel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [5:0]  stall;
    logic        flush;
    logic        ce;
    logic [31:0] addr;
    logic [31:0] dat;
    logic        ack;
    logic [31:0] e_data;
    logic        e_sr;
    logic        e_cyc;
    logic [31:0] e_adr;
    logic        e_err;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic r, input logic [5:0] s, input logic f, input logic c,
                     input logic [31:0] a, input logic [31:0] d, input logic k,
                     input logic [31:0] ed, input logic esr, input logic ecyc,
                     input logic [31:0] eadr, input logic eerr);
    vec_t v;
    v.rst = r; v.stall = s; v.flush = f; v.ce = c; v.addr = a; v.dat = d; v.ack = k;
    v.e_data = ed; v.e_sr = esr; v.e_cyc = ecyc; v.e_adr = eadr; v.e_err = eerr;
    vq.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic [5:0] s, input logic f, input logic c,
                       input logic [31:0] a, input logic [31:0] d, input logic k);
    rst = r; stall = s; flush = f; ce = c; addr = a; wb_dat = d; wb_ack = k;
  endtask

  // Check every output against the expected bus/cpu view for the current cycle.
  task automatic chk_all(input string tag, input logic [31:0] ed, input logic esr,
                         input logic ecyc, input logic [31:0] eadr, input logic eerr);
    chk({tag, ".cpu_data"}, cpu_data, ed);
    chk({tag, ".stallreq"}, 32'(stallreq), 32'(esr));
    chk({tag, ".cyc"}, 32'(wb_cyc), 32'(ecyc));
    chk({tag, ".stb"}, 32'(wb_stb), 32'(ecyc));
    chk({tag, ".sel"}, 32'(wb_sel), ecyc ? 32'hF : 32'h0);
    chk({tag, ".adr"}, wb_adr, eadr);
    chk({tag, ".err"}, 32'(err), 32'(eerr));
    chk({tag, ".we"}, 32'(wb_we), 32'h0);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Transaction-level fetch model.
  bit          m_fetching;
  bit          m_holding;
  int          m_age;
  logic [31:0] m_held;
  logic [31:0] m_adr;
  bit          m_err;

  initial begin
    logic [31:0] ed;
    logic        esr;
    drive(1'b0, 6'd0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    #1;
    next_cycle();
    next_cycle();
    drive(1'b1, 6'd0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    @(negedge clk);
    chk_all("reset", NOP, 1'b0, 1'b0, 32'h0, 1'b0);
    next_cycle();

    // Single fetch, ack in the first BUSY cycle.
    add(1, 6'd0, 0, 1, 32'h100, 32'h0,        0, NOP,          1, 0, 32'h0,   0);
    add(1, 6'd0, 0, 0, 32'h0,   32'h24020005, 1, 32'h24020005, 0, 1, 32'h100, 0);
    add(1, 6'd0, 0, 0, 32'h0,   32'h0,        0, NOP,          0, 0, 32'h100, 0);
    // Three wait states; ack arrives on the last cycle before timeout; PC change ignored.
    add(1, 6'd0, 0, 1, 32'h200, 32'h0,        0, NOP,          1, 0, 32'h100, 0);
    add(1, 6'd0, 0, 1, 32'h200, 32'h0,        0, NOP,          1, 1, 32'h200, 0);
    add(1, 6'd0, 0, 1, 32'h999, 32'h0,        0, NOP,          1, 1, 32'h200, 0);
    add(1, 6'd0, 0, 1, 32'h200, 32'h0,        0, NOP,          1, 1, 32'h200, 0);
    add(1, 6'd0, 0, 1, 32'h200, 32'h11112222, 1, 32'h11112222, 0, 1, 32'h200, 0);
    // Ack during pipeline stall, held data, late ack ignored, then next fetch.
    add(1, 6'd0, 0, 1, 32'h300, 32'h0,        0, NOP,          1, 0, 32'h200, 0);
    add(1, 6'd3, 0, 1, 32'h300, 32'hCAFEF00D, 1, 32'hCAFEF00D, 0, 1, 32'h300, 0);
    add(1, 6'd3, 0, 1, 32'h300, 32'h55555555, 1, 32'hCAFEF00D, 0, 0, 32'h300, 0);
    add(1, 6'd3, 0, 1, 32'h300, 32'h0,        0, 32'hCAFEF00D, 0, 0, 32'h300, 0);
    add(1, 6'd0, 0, 1, 32'h400, 32'h0,        0, 32'hCAFEF00D, 0, 0, 32'h300, 0);
    add(1, 6'd0, 0, 1, 32'h400, 32'h0,        0, NOP,          1, 0, 32'h300, 0);
    add(1, 6'd0, 0, 0, 32'h0,   32'h00000013, 1, 32'h00000013, 0, 1, 32'h400, 0);
    // Flush coincident with ack discards the data; flush in IDLE blocks a start.
    add(1, 6'd0, 0, 1, 32'h500, 32'h0,        0, NOP,          1, 0, 32'h400, 0);
    add(1, 6'd3, 1, 1, 32'h500, 32'hDEADBEEF, 1, NOP,          0, 1, 32'h500, 0);
    add(1, 6'd3, 0, 0, 32'h0,   32'h0,        0, NOP,          0, 0, 32'h500, 0);
    add(1, 6'd0, 1, 1, 32'h580, 32'h0,        0, NOP,          0, 0, 32'h500, 0);
    add(1, 6'd0, 0, 0, 32'h0,   32'h0,        0, NOP,          0, 0, 32'h500, 0);
    // Hung slave: four BUSY cycles then abort, one-cycle err pulse, late ack ignored.
    add(1, 6'd0, 0, 1, 32'h600, 32'h0,        0, NOP,          1, 0, 32'h500, 0);
    add(1, 6'd0, 0, 0, 32'h0,   32'h0,        0, NOP,          1, 1, 32'h600, 0);
    add(1, 6'd0, 0, 0, 32'h0,   32'h0,        0, NOP,          1, 1, 32'h600, 0);
    add(1, 6'd0, 0, 0, 32'h0,   32'h0,        0, NOP,          1, 1, 32'h600, 0);
    add(1, 6'd0, 0, 0, 32'h0,   32'h0,        0, NOP,          0, 1, 32'h600, 0);
    add(1, 6'd0, 0, 0, 32'h0,   32'h77,       1, NOP,          0, 0, 32'h600, 1);
    add(1, 6'd0, 0, 0, 32'h0,   32'h0,        0, NOP,          0, 0, 32'h600, 0);

    for (int i = 0; i < vq.size(); i++) begin
      drive(vq[i].rst, vq[i].stall, vq[i].flush, vq[i].ce, vq[i].addr, vq[i].dat, vq[i].ack);
      @(negedge clk);
      chk_all($sformatf("vec%0d", i), vq[i].e_data, vq[i].e_sr, vq[i].e_cyc, vq[i].e_adr, vq[i].e_err);
      next_cycle();
    end

    // Reset mid-BUSY: bus drops, address clears, no error, later ack ignored.
    drive(1, 6'd0, 0, 1, 32'h700, 32'h0, 0);
    next_cycle();
    drive(0, 6'd0, 0, 0, 32'h0, 32'h0, 0);
    @(negedge clk);
    chk_all("rstbusy.pre", NOP, 1'b1, 1'b1, 32'h700, 1'b0);
    next_cycle();
    drive(1, 6'd0, 0, 0, 32'h0, 32'hABCD0123, 1);
    @(negedge clk);
    chk_all("rstbusy.post", NOP, 1'b0, 1'b0, 32'h0, 1'b0);
    next_cycle();
    drive(1, 6'd0, 0, 0, 32'h0, 32'h0, 0);
    @(negedge clk);
    chk_all("rstbusy.idle", NOP, 1'b0, 1'b0, 32'h0, 1'b0);
    next_cycle();

    // Reset on the timeout cycle suppresses the err pulse.
    drive(1, 6'd0, 0, 1, 32'h800, 32'h0, 0);
    next_cycle();
    drive(1, 6'd0, 0, 0, 32'h0, 32'h0, 0);
    for (int i = 0; i < int'(TMO) - 1; i++) next_cycle();
    drive(0, 6'd0, 0, 0, 32'h0, 32'h0, 0);
    next_cycle();
    drive(1, 6'd0, 0, 0, 32'h0, 32'h0, 0);
    @(negedge clk);
    chk_all("rsttmo", NOP, 1'b0, 1'b0, 32'h0, 1'b0);
    next_cycle();

    // Random traffic against the model.
    m_fetching = 0; m_holding = 0; m_age = 0; m_held = '0; m_adr = '0; m_err = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      logic        r_rst, r_flush, r_ce, r_ack;
      logic [5:0]  r_stall;
      logic [31:0] r_addr, r_dat;
      bit          next_err;
      r_rst   = ($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1;
      r_stall = 6'($urandom);
      r_flush = ($urandom_range(0, 19) == 0);
      r_ce    = ($urandom_range(0, 3) != 0);
      r_addr  = $urandom & 32'hFFFF_FFFC;
      r_dat   = $urandom;
      r_ack   = ($urandom_range(0, 2) == 0);
      drive(r_rst, r_stall, r_flush, r_ce, r_addr, r_dat, r_ack);

      ed = NOP;
      esr = 1'b0;
      if (m_holding) begin
        ed = m_held;
      end else if (m_fetching) begin
        if (!r_flush && r_ack) ed = r_dat;
        else if (!r_flush && (m_age + 1 < int'(TMO))) esr = 1'b1;
      end else begin
        esr = r_ce && !r_flush;
      end
      @(negedge clk);
      chk_all($sformatf("rnd%0d", cyc), ed, esr, m_fetching, m_adr, m_err);

      next_err = 0;
      if (!r_rst) begin
        m_fetching = 0; m_holding = 0; m_adr = '0; m_age = 0;
      end else if (m_holding) begin
        if (r_flush || !r_stall[1]) m_holding = 0;
      end else if (m_fetching) begin
        if (r_flush) begin
          m_fetching = 0;
        end else if (r_ack) begin
          m_fetching = 0;
          m_holding  = r_stall[1];
          m_held     = r_dat;
        end else if (m_age + 1 == int'(TMO)) begin
          m_fetching = 0;
          next_err   = 1;
        end else begin
          m_age++;
        end
      end else if (r_ce && !r_flush) begin
        m_fetching = 1;
        m_adr      = r_addr;
        m_age      = 0;
      end
      m_err = next_err;
      next_cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
